// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Hazard controller for a 5-stage pipeline. It handles
//                load-use and RAW stalls, branch and jump flushes, and
//                EX-stage operand forwarding selects. It also keeps
//                saturating stall and flush event counters.
//                Optional macro HAZARD_FORWARD_EN enables forwarding. With
//                forwarding, only load-use hazards stall. Without it, any
//                RAW hazard against EX or MEM stalls, and the forward
//                selects stay at 00.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_jump,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic [4:0]  mem_rd,
    input  logic [4:0]  wb_rd,
    input  logic        mem_reg_write,
    input  logic        wb_reg_write,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    state_t      state_q, state_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic        w_ex_hit;
    logic        w_stall_cond;
    logic        w_stall;
    logic        w_jump;
    logic [1:0]  w_fwd_a;
    logic [1:0]  w_fwd_b;

    // Register 0 is hardwired, so a destination of 0 never creates a hazard.
    assign w_ex_hit = (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

`ifdef HAZARD_FORWARD_EN
    // Only a load in EX cannot be bypassed in time; everything else forwards.
    assign w_stall_cond = ex_mem_read && ex_reg_write && w_ex_hit;

    // Forward selects; MEM holds the younger result, so it wins over WB.
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs))
            w_fwd_a = 2'b10;
        else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs))
            w_fwd_a = 2'b01;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rt))
            w_fwd_b = 2'b10;
        else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rt))
            w_fwd_b = 2'b01;
    end
`else
    logic w_mem_hit;
    logic w_unused_nofwd;

    assign w_mem_hit = (mem_rd != 5'd0) &&
                       ((mem_rd == id_rs) || (id_uses_rt && (mem_rd == id_rt)));

    // With no bypass network, ID waits until the producer leaves MEM.
    // The register file writes in the first half-cycle, so WB never hazards.
    assign w_stall_cond   = (ex_reg_write && w_ex_hit) || (mem_reg_write && w_mem_hit);
    assign w_fwd_a        = 2'b00;
    assign w_fwd_b        = 2'b00;
    assign w_unused_nofwd = ^{ex_rs, ex_rt, ex_mem_read, wb_rd, wb_reg_write};
`endif

    // Priority is branch > stall > jump. Stall detection is masked in
    // FLUSH because ID then holds a bubble.
    assign w_stall = w_stall_cond && (state_q != ST_FLUSH) && !ex_branch_taken;
    assign w_jump  = id_jump && !ex_branch_taken && !w_stall;

    // Same-cycle pipeline control. During reset, the outputs force bubbles
    // everywhere and freeze the PC.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        fwd_a      = w_fwd_a;
        fwd_b      = w_fwd_b;
        if (!rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            fwd_a      = 2'b00;
            fwd_b      = 2'b00;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end else if (w_jump) begin
            ifid_flush = 1'b1;
        end
    end

    // Next state and saturating event counters.
    always_comb begin
        state_d     = ST_RUN;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (ex_branch_taken || w_jump)
            state_d = ST_FLUSH;
        else if (w_stall)
            state_d = ST_STALL;
        if (w_stall && (stall_cnt_q != C_CNT_MAX))
            stall_cnt_d = stall_cnt_q + 16'd1;
        if ((ex_branch_taken || w_jump) && (flush_cnt_q != C_CNT_MAX))
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    // State and counter registers; reset abandons any stall or flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Self-checking bench for pipe_hazard_ctrl. It uses an
//                abstract reference model with random and directed stimulus.
//                The build mode follows the HAZARD_FORWARD_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic        id_uses_rt, id_jump, ex_reg_write, ex_mem_read, ex_branch_taken;
    logic        mem_reg_write, wb_reg_write;
    logic        pc_write, ifid_write, ifid_flush, idex_flush;
    logic [1:0]  fwd_a, fwd_b, state;
    logic [15:0] stall_cnt, flush_cnt;

    int vectors     = 0;
    int comparisons = 0;
    int miscompares = 0;

    // Model state: 0 RUN, 1 STALL, 2 FLUSH; counters as plain integers.
    int mstate = 0;
    int mstall = 0;
    int mflush = 0;
    bit mvalid = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
    );

    task automatic chk(input string name, input int act, input int exp);
        comparisons++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit hits(input logic [4:0] d);
        return (d != 0) && ((d == id_rs) || (id_uses_rt && (d == id_rt)));
    endfunction

    function automatic int fwdsel(input logic [4:0] s);
`ifdef HAZARD_FORWARD_EN
        if (mem_reg_write && mem_rd != 0 && mem_rd == s) return 2;
        if (wb_reg_write && wb_rd != 0 && wb_rd == s) return 1;
`endif
        return 0;
    endfunction

    // Compare all outputs against the model, then advance the model.
    task automatic compare_and_advance();
        bit cond, br, stl, jmp;
        int epw, eiw, eif, exf, efa, efb;
        cond = 0; br = 0; stl = 0; jmp = 0;
        if (!rst) begin
            epw = 0; eiw = 0; eif = 1; exf = 1; efa = 0; efb = 0;
        end else begin
`ifdef HAZARD_FORWARD_EN
            cond = ex_mem_read && ex_reg_write && hits(ex_rd);
`else
            cond = (ex_reg_write && hits(ex_rd)) || (mem_reg_write && hits(mem_rd));
`endif
            if (mstate == 2) cond = 0;
            br  = ex_branch_taken;
            stl = cond && !br;
            jmp = id_jump && !br && !stl;
            epw = (br || !stl) ? 1 : 0;
            eiw = stl ? 0 : 1;
            eif = (br || jmp) ? 1 : 0;
            exf = (br || stl) ? 1 : 0;
            efa = fwdsel(ex_rs);
            efb = fwdsel(ex_rt);
        end
        chk("pc_write", int'(pc_write), epw);
        chk("ifid_write", int'(ifid_write), eiw);
        chk("ifid_flush", int'(ifid_flush), eif);
        chk("idex_flush", int'(idex_flush), exf);
        chk("fwd_a", int'(fwd_a), efa);
        chk("fwd_b", int'(fwd_b), efb);
        if (mvalid) begin
            chk("state", int'(state), mstate);
            chk("stall_cnt", int'(stall_cnt), mstall);
            chk("flush_cnt", int'(flush_cnt), mflush);
        end
        if (!rst) begin
            mstate = 0; mstall = 0; mflush = 0; mvalid = 1;
        end else begin
            mstate = br ? 2 : (stl ? 1 : (jmp ? 2 : 0));
            if (stl && mstall < 65535) mstall++;
            if ((br || jmp) && mflush < 65535) mflush++;
        end
    endtask

    // Inputs are set just after a rising edge; check on the falling edge.
    task automatic step();
        @(negedge clk);
        vectors++;
        compare_and_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_jump = 0;
        ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
        ex_branch_taken = 0; mem_rd = 0; wb_rd = 0;
        mem_reg_write = 0; wb_reg_write = 0;
    endtask

    task automatic randomize_inputs();
        rst             = ($urandom_range(0, 63) != 0);
        id_rs           = 5'($urandom_range(0, 3));
        id_rt           = 5'($urandom_range(0, 3));
        ex_rs           = 5'($urandom_range(0, 3));
        ex_rt           = 5'($urandom_range(0, 3));
        ex_rd           = 5'($urandom_range(0, 3));
        mem_rd          = 5'($urandom_range(0, 3));
        wb_rd           = 5'($urandom_range(0, 3));
        id_uses_rt      = 1'($urandom_range(0, 1));
        id_jump         = ($urandom_range(0, 5) == 0);
        ex_reg_write    = 1'($urandom_range(0, 1));
        ex_mem_read     = ($urandom_range(0, 2) == 0);
        ex_branch_taken = ($urandom_range(0, 7) == 0);
        mem_reg_write   = 1'($urandom_range(0, 1));
        wb_reg_write    = 1'($urandom_range(0, 1));
    endtask

    int base_s, base_f;

    initial begin
        idle();
        rst = 0;
        #1;
        step();
        step();
        chk("rst_state", int'(state), 0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        chk("rst_flush_cnt", int'(flush_cnt), 0);
        #1;
        chk("rst_pc_write", int'(pc_write), 0);
        chk("rst_ifid_flush", int'(ifid_flush), 1);

        // Zero register never hazards.
        idle();
        ex_rd = 0; ex_mem_read = 1; ex_reg_write = 1; id_rs = 0;
        mem_rd = 0; mem_reg_write = 1;
        #1;
        chk("zero_pc_write", int'(pc_write), 1);
        chk("zero_fwd_a", int'(fwd_a), 0);
        step();
        chk("zero_state", int'(state), 0);

        // Branch beats load-use stall.
        idle();
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5; id_rs = 5; ex_branch_taken = 1;
        #1;
        chk("br_ifid_flush", int'(ifid_flush), 1);
        chk("br_idex_flush", int'(idex_flush), 1);
        chk("br_pc_write", int'(pc_write), 1);
        step();
        chk("br_state", int'(state), 2);
        chk("br_flush_cnt", int'(flush_cnt), 1);
        chk("br_stall_cnt", int'(stall_cnt), 0);
        idle();
        step();
        chk("br_exit_state", int'(state), 0);

`ifdef HAZARD_FORWARD_EN
        // Load-use stalls exactly one cycle.
        base_s = int'(stall_cnt);
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5; id_rs = 5;
        #1;
        chk("lu_pc_write", int'(pc_write), 0);
        chk("lu_idex_flush", int'(idex_flush), 1);
        step();
        chk("lu_state", int'(state), 1);
        chk("lu_stall_cnt", int'(stall_cnt), base_s + 1);
        idle();
        step();
        chk("lu_exit_state", int'(state), 0);

        // MEM forward beats WB forward.
        idle();
        ex_rs = 3; mem_rd = 3; wb_rd = 3; mem_reg_write = 1; wb_reg_write = 1;
        #1;
        chk("fwd_mem", int'(fwd_a), 2);
        step();
        mem_reg_write = 0;
        #1;
        chk("fwd_wb", int'(fwd_a), 1);
        step();
`else
        // RAW without forwarding stalls while the producer is in EX, then MEM.
        base_s = int'(stall_cnt);
        ex_rd = 7; ex_reg_write = 1; id_rt = 7; id_uses_rt = 1;
        #1;
        chk("raw1_pc_write", int'(pc_write), 0);
        step();
        chk("raw1_state", int'(state), 1);
        ex_rd = 0; ex_reg_write = 0; mem_rd = 7; mem_reg_write = 1;
        step();
        chk("raw2_state", int'(state), 1);
        mem_rd = 0; mem_reg_write = 0; wb_rd = 7; wb_reg_write = 1;
        #1;
        chk("raw_exit_pc_write", int'(pc_write), 1);
        step();
        chk("raw_stall_cnt", int'(stall_cnt), base_s + 2);
        chk("raw_exit_state", int'(state), 0);
        chk("raw_fwd_b", int'(fwd_b), 0);
`endif

        // Randomized traffic checked against the model.
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            step();
        end

        // Saturation of stall_cnt, then reset while stalled.
        idle();
        rst = 0;
        step();
        idle();
        base_f = int'(flush_cnt);
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5; id_rs = 5;
        for (int i = 0; i < 65540; i++) step();
        chk("sat_stall_cnt", int'(stall_cnt), 16'hFFFF);
        chk("sat_state", int'(state), 1);
        chk("sat_flush_cnt", int'(flush_cnt), base_f);
        rst = 0;
        step();
        chk("rst_mid_state", int'(state), 0);
        chk("rst_mid_stall_cnt", int'(stall_cnt), 0);
        chk("rst_mid_flush_cnt", int'(flush_cnt), 0);
        rst = 1;
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have ports (name direction width meaning):
  clk  in  1  single clock; all state updates on rising edge
  rst  in  1  synchronous, active-low reset
  id_rs, id_rt  in  5 each  source registers of instruction in ID
  id_uses_rt  in  1  ID instruction reads rt (R-type, BEQ, SW)
  id_jump  in  1  jump decoded in ID
  ex_rs, ex_rt  in  5 each  source registers of instruction in EX
  ex_rd  in  5  destination register of EX instruction
  ex_reg_write, ex_mem_read  in  1 each  EX instruction writes a register / is LW
  ex_branch_taken  in  1  BEQ resolved taken in EX
  mem_rd, wb_rd  in  5 each  destinations in MEM, WB
  mem_reg_write, wb_reg_write  in  1 each  MEM/WB write enables
  pc_write, ifid_write  out  1 each  PC / IF-ID register update enable
  ifid_flush, idex_flush  out  1 each  insert bubble into IF-ID / ID-EX
  fwd_a, fwd_b  out  2 each  EX operand source: 00 regfile, 10 MEM, 01 WB
  stall_cnt, flush_cnt  out  16 each  event counters
  state  out  2  FSM state: 00 RUN, 01 STALL, 10 FLUSH

Function
REQ-002 SHALL treat register 0 as never hazarding: any comparison against destination 0 is a non-match.
REQ-003 SHALL define hazard source match m(src) = src equals a writing destination, with rt counted only when id_uses_rt=1.
REQ-004 SHALL raise ex_branch_taken flush: ifid_flush=1, idex_flush=1, pc_write=1, in the same cycle (combinational); next state FLUSH.
REQ-005 SHALL, on id_jump=1 with no branch taken, assert ifid_flush=1 only, in the same cycle; next state FLUSH.
REQ-006 SHALL, on stall condition with no branch taken, drive pc_write=0, ifid_write=0, idex_flush=1 in the same cycle; next state STALL.
REQ-007 SHALL otherwise drive pc_write=1, ifid_write=1, both flushes 0; next state RUN.
REQ-008 SHALL give priority: ex_branch_taken > stall > id_jump (jump in a stalled ID waits until the stall clears).
REQ-009 SHALL, in state FLUSH, suppress stall detection for that one cycle (ID holds a bubble); FLUSH always exits after one cycle unless a new flush/stall occurs.
REQ-010 SHALL remain in STALL for as many consecutive cycles as the stall condition holds; the exit cycle is the first with condition false.
REQ-011 SHALL increment stall_cnt on every cycle with stall asserted and flush_cnt on every cycle with ifid_flush=1; both saturate at 16'hFFFF.
REQ-012 SHALL keep stall and flush mutually exclusive in any cycle (a branch flush counts only as flush).

Reset
REQ-013 SHALL, when rst=0 at a rising edge, set state=RUN, stall_cnt=0, flush_cnt=0; outputs during reset: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, fwd_a=fwd_b=00.
REQ-014 SHALL abandon any stall or flush in progress on reset; first cycle after rst=1 evaluates from RUN.

Configuration
REQ-015 SHALL honour macro HAZARD_FORWARD_EN.
REQ-016 With HAZARD_FORWARD_EN defined: stall condition = ex_mem_read and ex_reg_write and m(ex_rd) (load-use, exactly 1 cycle); fwd_a/fwd_b = 10 if mem_reg_write and mem_rd matches ex_rs/ex_rt, else 01 if wb_reg_write and wb_rd matches, else 00 (MEM has priority).
REQ-017 Without HAZARD_FORWARD_EN: stall condition = (ex_reg_write and m(ex_rd)) or (mem_reg_write and m(mem_rd)); RAW stalls last up to 2 cycles; fwd_a=fwd_b=00 permanently (regfile writes first half-cycle).

Verification
REQ-018 Load-use (FWD_EN): ex_mem_read=1, ex_rd=5, id_rs=5 -> one cycle pc_write=0, idex_flush=1, state=STALL, stall_cnt 0->1, then RUN.
REQ-019 Forward priority (FWD_EN): ex_rs=3, mem_rd=3, wb_rd=3, both writes=1 -> fwd_a=10; mem_reg_write=0 -> fwd_a=01.
REQ-020 Zero register: ex_rd=0, ex_mem_read=1, id_rs=0 -> no stall, pc_write=1, fwd_a=00.
REQ-021 Branch beats stall: load-use plus ex_branch_taken=1 same cycle -> ifid_flush=idex_flush=1, pc_write=1, flush_cnt+1, stall_cnt unchanged, state=FLUSH.
REQ-022 No-forward RAW: ex_rd=7 writing, id_rt=7, id_uses_rt=1 -> 2 stall cycles as instruction moves EX->MEM, stall_cnt=2, then RUN.
REQ-023 Saturation/reset: preload stall_cnt to 16'hFFFF, stall again -> stays 16'hFFFF; rst=0 mid-STALL -> next cycle state=RUN, counters 0.
